pcap_inter_packet_delay: RTL and testbench
==========================================

Name: pcap_inter_packet_delay

Overview:
- Sits directly downstream of the pcap replay micro-engine master stream, before the output port queues.
- Enforces the per-packet inter-packet gap (IPD) carried in tuser, or a register-forced gap, by holding the first beat of each packet until enough idle cycles have elapsed since the previous packet's last beat.
- Passes packet data, tstrb and tuser through unmodified; zero added latency once a packet is released.

Parameters:
- C_AXIS_DATA_WIDTH, 256, stream data width (tstrb = C_AXIS_DATA_WIDTH/8)
- C_AXIS_TUSER_WIDTH, 128, tuser width
- DELAY_WIDTH, 32, width of gap value and gap counter
- DELAY_LSB, 32, bit position in tuser of the per-packet gap field, tuser[DELAY_LSB +: DELAY_WIDTH]

Ports:
- axi_aclk  in  1  sole clock
- axi_reset  in  1  synchronous, active-high reset
- s_axis_tdata  in  C_AXIS_DATA_WIDTH  from replay engine
- s_axis_tstrb  in  C_AXIS_DATA_WIDTH/8  byte strobes
- s_axis_tuser  in  C_AXIS_TUSER_WIDTH  metadata; gap field on first beat only
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- s_axis_tlast  in  1
- m_axis_tdata / tstrb / tuser / tlast  out  same widths  pass-through of s_axis_*
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- ipd_en  in  1  0 = bypass (no gap enforced)
- ipd_use_reg  in  1  1 = use ipd_reg_value instead of the tuser field
- ipd_reg_value  in  DELAY_WIDTH  register-forced gap in cycles
- busy  out  1  high when in HOLD or SEND

Behaviour:
- Reset (synchronous, axi_reset=1 at a clock edge):
  - state = IDLE.
  - gap_cnt saturates to all-ones, so the first packet after reset is never held.
  - m_axis_tvalid = 0, s_axis_tready = 0, busy = 0.
- gap_cnt:
  - Cleared to 0 on the cycle a beat with tlast is accepted (s_tvalid & s_tready & s_tlast).
  - Otherwise increments by 1 each cycle and saturates at 2^DELAY_WIDTH-1; no wrap.
- Gap value, sampled from the first beat:
  - target = ipd_use_reg ? ipd_reg_value : s_axis_tuser[DELAY_LSB +: DELAY_WIDTH].
  - The target is registered when HOLD is entered.
- release = (ipd_en == 0) | (gap_cnt >= target). Comparison is unsigned and full width.
- States:
  - IDLE:
    - Ready and valid are gated low.
    - When s_tvalid=1 and release (evaluated with the live target) holds, go to SEND in the same cycle: the first beat passes combinationally.
    - When s_tvalid=1 and release does not hold, latch the target and go to HOLD.
  - HOLD:
    - m_tvalid = 0, s_tready = 0.
    - Go to SEND on the cycle gap_cnt >= latched target, or when ipd_en drops to 0.
    - Changes to ipd_reg_value while in HOLD are ignored.
  - SEND:
    - m_tvalid = s_tvalid, s_tready = m_tready; data, tstrb, tuser and tlast are combinational.
    - On an accepted tlast beat, return to IDLE; gap_cnt clears on that same edge.
- Gap semantics:
  - target N means at least N full cycles with m_tvalid=0 between the last-beat handshake and the next first-beat presentation.
  - N=0 means back-to-back packets with no idle cycle.
- Single-beat packet (tlast on first beat): IDLE→SEND→IDLE, accepted in one cycle when released and m_tready=1.
- Downstream backpressure: in SEND, m_tready=0 stalls the transfer; valid and data are held stable by the upstream AXIS contract. The gap is measured from the handshake, not from tvalid.
- The tuser gap field is forwarded untouched.
- Reset mid-packet:
  - Returns to IDLE immediately.
  - The remainder of the partial packet is treated as a new packet; the upstream engine is reset by the same sw_rst, so this case is benign.
- AXIS protocol: never asserts m_tvalid without s_tvalid; never combinationally depends on m_tvalid to drive s_tready.

Optional Feature:
- Macro: PCAP_IPD_STATS_EN.
- Defined:
  - Adds outputs stat_pkt_cnt[31:0] (packets forwarded, counts tlast handshakes) and stat_hold_cycles[31:0] (cycles spent in HOLD).
  - Both counters saturate, clear on axi_reset, and also clear on the input stat_clr (1 bit, synchronous).
- Not defined: those ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package pcap_ipd_pkg holds:
  - state encoding localparams IDLE=2'd0, HOLD=2'd1, SEND=2'd2;
  - default DELAY_LSB and DELAY_WIDTH;
  - the gap-counter saturation constant.
- One natural sub-module, pcap_ipd_gap_counter: saturating counter with clear-on-tlast and the >= compare. The top level holds the FSM and handshake muxing.

Test Plan:
- After reset, ipd_en=1, first packet with tuser gap=1000, m_tready=1 → forwarded with no hold (gap_cnt saturated).
- Two 4-beat packets presented back-to-back, the second with gap=10 → exactly 10 cycles with m_tvalid=0 between the first tlast handshake and the second packet's first beat.
- Gap=0 on consecutive single-beat packets, m_tready=1 → one packet per cycle, no bubbles.
- ipd_use_reg=1, ipd_reg_value=5, tuser gap=100 → 5-cycle gap. Then drop ipd_en mid-HOLD → release on the next cycle.
- m_tready toggling 1/0 every cycle during SEND of an 8-beat packet → all 8 beats delivered in order, data stable while stalled, gap counted from the final handshake.
- Assert axi_reset in HOLD, then in SEND mid-packet → m_tvalid=0 and s_tready=0 the following cycle, state IDLE. With PCAP_IPD_STATS_EN: after 3 packets, stat_pkt_cnt=3; stat_clr → 0.

Source files
------------

// File: rtl/pcap_ipd_pkg.sv
// Shared definitions for the pcap inter-packet delay block.
package pcap_ipd_pkg;

    localparam int unsigned DEFAULT_DELAY_LSB   = 32;
    localparam int unsigned DEFAULT_DELAY_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        HOLD = ST_HOLD,
        SEND = ST_SEND
    } ipd_state_e;

    // Value the gap counter parks at after reset and when idle for a long time.
    localparam logic [DEFAULT_DELAY_WIDTH-1:0] GAP_CNT_SAT = '1;

endpackage

// File: rtl/pcap_ipd_gap_counter.sv
// Idle-cycle counter since the last accepted tlast beat, with release compares.
// gap_cnt parks at all-ones after reset so the first packet is never held.
module pcap_ipd_gap_counter
    import pcap_ipd_pkg::*;
#(
    parameter int unsigned DELAY_WIDTH = DEFAULT_DELAY_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic [DELAY_WIDTH-1:0] live_target,
    input  logic [DELAY_WIDTH-1:0] hold_target,
    output logic                   live_ge,
    output logic                   hold_ge
);

    logic [DELAY_WIDTH-1:0] gap_cnt;

    // Saturating count of cycles since the last tlast handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt <= '1;
        end else if (clr) begin
            gap_cnt <= '0;
        end else if (gap_cnt != '1) begin
            gap_cnt <= gap_cnt + DELAY_WIDTH'(1);
        end
    end

    assign live_ge = (gap_cnt >= live_target);
    assign hold_ge = (gap_cnt >= hold_target);

endmodule

// File: rtl/pcap_inter_packet_delay.sv
// Holds the first beat of each packet until the programmed inter-packet gap
// has elapsed since the previous packet's last handshake; data passes through.
// Optional statistics counters are built when PCAP_IPD_STATS_EN is defined.
module pcap_inter_packet_delay
    import pcap_ipd_pkg::*;
#(
    parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned DELAY_WIDTH        = DEFAULT_DELAY_WIDTH,
    parameter int unsigned DELAY_LSB          = DEFAULT_DELAY_LSB
) (
    input  logic                            axi_aclk,
    input  logic                            axi_reset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    input  logic                            ipd_en,
    input  logic                            ipd_use_reg,
    input  logic [DELAY_WIDTH-1:0]          ipd_reg_value,
`ifdef PCAP_IPD_STATS_EN
    input  logic                            stat_clr,
    output logic [31:0]                     stat_pkt_cnt,
    output logic [31:0]                     stat_hold_cycles,
`endif
    output logic                            busy
);

    ipd_state_e             state;
    ipd_state_e             state_nxt;
    logic [DELAY_WIDTH-1:0] live_target;
    logic [DELAY_WIDTH-1:0] hold_target;
    logic                   live_ge;
    logic                   hold_ge;
    logic                   pass;
    logic                   hold_load;
    logic                   last_hs;

    assign live_target = ipd_use_reg ? ipd_reg_value
                                     : s_axis_tuser[DELAY_LSB +: DELAY_WIDTH];

    assign last_hs = s_axis_tvalid & s_axis_tready & s_axis_tlast;

    pcap_ipd_gap_counter #(
        .DELAY_WIDTH (DELAY_WIDTH)
    ) u_gap_counter (
        .clk         (axi_aclk),
        .rst         (axi_reset),
        .clr         (last_hs),
        .live_target (live_target),
        .hold_target (hold_target),
        .live_ge     (live_ge),
        .hold_ge     (hold_ge)
    );

    // State register.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Gap target captured on entry to HOLD; later register changes are ignored.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            hold_target <= '0;
        end else if (hold_load) begin
            hold_target <= live_target;
        end
    end

    // Next state and pass-through gating; a released first beat passes in the same cycle.
    always_comb begin
        state_nxt = state;
        pass      = 1'b0;
        hold_load = 1'b0;
        case (state)
            IDLE: begin
                if (!ipd_en || live_ge) begin
                    pass = 1'b1;
                    if (s_axis_tvalid && !(m_axis_tready && s_axis_tlast)) begin
                        state_nxt = SEND;
                    end
                end else if (s_axis_tvalid) begin
                    hold_load = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!ipd_en || hold_ge) begin
                    pass      = 1'b1;
                    state_nxt = (s_axis_tvalid && m_axis_tready && s_axis_tlast) ? IDLE : SEND;
                end
            end
            SEND: begin
                pass = 1'b1;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (axi_reset) begin
            pass = 1'b0;
        end
    end

    assign m_axis_tvalid = pass & s_axis_tvalid;
    assign s_axis_tready = pass & m_axis_tready;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tstrb  = s_axis_tstrb;
    assign m_axis_tuser  = s_axis_tuser;
    assign m_axis_tlast  = s_axis_tlast;
    assign busy          = (state != IDLE);

`ifdef PCAP_IPD_STATS_EN
    // Saturating packet and hold-cycle counters.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset || stat_clr) begin
            stat_pkt_cnt     <= '0;
            stat_hold_cycles <= '0;
        end else begin
            if (last_hs && (stat_pkt_cnt != '1)) begin
                stat_pkt_cnt <= stat_pkt_cnt + 32'(1);
            end
            if ((state == HOLD) && (stat_hold_cycles != '1)) begin
                stat_hold_cycles <= stat_hold_cycles + 32'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pcap_inter_packet_delay.sv
// Self-checking bench for pcap_inter_packet_delay (optionally with PCAP_IPD_STATS_EN).
module tb_pcap_inter_packet_delay;

    localparam int unsigned DW = 256;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned UW = 128;
    localparam longint      NEVER = 64'sd1_000_000_000;

    typedef struct {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          axi_reset;
    logic [DW-1:0] s_axis_tdata;
    logic [SW-1:0] s_axis_tstrb;
    logic [UW-1:0] s_axis_tuser;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [SW-1:0] m_axis_tstrb;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          ipd_en;
    logic          ipd_use_reg;
    logic [31:0]   ipd_reg_value;
    logic          busy;
`ifdef PCAP_IPD_STATS_EN
    logic          stat_clr;
    logic [31:0]   stat_pkt_cnt;
    logic [31:0]   stat_hold_cycles;
`endif

    pcap_inter_packet_delay dut (
        .axi_aclk      (clk),
        .axi_reset     (axi_reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .ipd_en        (ipd_en),
        .ipd_use_reg   (ipd_use_reg),
        .ipd_reg_value (ipd_reg_value),
`ifdef PCAP_IPD_STATS_EN
        .stat_clr         (stat_clr),
        .stat_pkt_cnt     (stat_pkt_cnt),
        .stat_hold_cycles (stat_hold_cycles),
`endif
        .busy          (busy)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     n_cmp = 0;
    int     n_bad = 0;

    // Reference model state: expected beats and the gap rule for the next packet.
    beat_t  sb[$];
    longint last_hs = -NEVER;
    bit     in_pkt = 1'b0;
    bit     armed = 1'b0;
    longint exp_t;
    longint exp_n;
    bit     exp_bypass;
    longint exp_drop;
    bit     was_stall = 1'b0;
    logic [DW-1:0] stall_data;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: data order, stall stability and first-beat timing.
    initial begin
        forever begin
            @(negedge clk);
            if (axi_reset) begin
                sb.delete();
                in_pkt    = 1'b0;
                last_hs   = -NEVER;
                was_stall = 1'b0;
            end else begin
                if (m_axis_tvalid) chk("valid_needs_s_valid", DW'(s_axis_tvalid), DW'(1));
                if (was_stall) begin
                    chk("stall_valid_held", DW'(m_axis_tvalid), DW'(1));
                    chk("stall_data_held", m_axis_tdata, stall_data);
                end
                if (m_axis_tvalid && !in_pkt) begin
                    in_pkt = 1'b1;
                    if (armed) begin
                        longint e;
                        e = exp_bypass ? exp_t : ((last_hs + 1 + exp_n > exp_t) ? last_hs + 1 + exp_n : exp_t);
                        if (e > exp_drop) e = exp_drop;
                        chk("first_beat_cycle", DW'(cyc), DW'(e));
                        armed = 1'b0;
                    end
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    chk("beat_expected", DW'(sb.size() != 0), DW'(1));
                    if (sb.size() != 0) begin
                        beat_t b;
                        b = sb.pop_front();
                        chk("tdata", m_axis_tdata, b.d);
                        chk("tstrb", DW'(m_axis_tstrb), DW'(b.s));
                        chk("tuser", DW'(m_axis_tuser), DW'(b.u));
                        chk("tlast", DW'(m_axis_tlast), DW'(b.l));
                    end
                    if (m_axis_tlast) begin
                        in_pkt  = 1'b0;
                        last_hs = cyc;
                    end
                end
                was_stall  = m_axis_tvalid && !m_axis_tready;
                stall_data = m_axis_tdata;
            end
        end
    end

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input beat_t b);
        s_axis_tdata = b.d;
        s_axis_tstrb = b.s;
        s_axis_tuser = b.u;
        s_axis_tlast = b.l;
    endtask

    // Sends one packet; mode 0 tready=1, 1 toggling, 2 random.
    // poke_kind 1 zeroes ipd_reg_value, 2 drops ipd_en, at poke_k cycles after presentation.
    task automatic send_pkt(input int len, input int ugap, input int mode, input int poke_k, input int poke_kind);
        beat_t bt[$];
        int    beat;
        int    k;
        bit    hs;
        bit    tog;
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            b.s = $urandom;
            b.u = {$urandom, $urandom, 32'(ugap), $urandom};
            b.l = (i == len - 1);
            bt.push_back(b);
            sb.push_back(b);
        end
        exp_bypass = !ipd_en;
        exp_n      = ipd_use_reg ? longint'(ipd_reg_value) : longint'(ugap);
        exp_t      = cyc;
        exp_drop   = (poke_kind == 2) ? cyc + poke_k : NEVER;
        armed      = 1'b1;
        drive(bt[0]);
        s_axis_tvalid = 1'b1;
        beat = 0;
        k    = 0;
        tog  = 1'b1;
        while (beat < len && k < 400) begin
            case (mode)
                0:       m_axis_tready = 1'b1;
                1:       begin m_axis_tready = tog; tog = !tog; end
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            if (k == poke_k && poke_kind == 1) ipd_reg_value = 32'd0;
            if (k == poke_k && poke_kind == 2) ipd_en = 1'b0;
            @(negedge clk);
            hs = s_axis_tready;
            @(posedge clk);
            #1;
            k++;
            if (hs) begin
                beat++;
                if (beat < len) drive(bt[beat]);
            end
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        chk("pkt_complete", DW'(beat), DW'(len));
    endtask

    task automatic do_reset_check(input string tag);
        @(posedge clk); #1;
        axi_reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_busy"}, DW'(busy), DW'(0));
        chk({tag, "_m_tvalid"}, DW'(m_axis_tvalid), DW'(0));
        chk({tag, "_s_tready"}, DW'(s_axis_tready), DW'(0));
        @(posedge clk); #1;
        axi_reset     = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
    endtask

    initial begin
        longint c0;
        axi_reset     = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        ipd_en        = 1'b1;
        ipd_use_reg   = 1'b0;
        ipd_reg_value = 32'd0;
`ifdef PCAP_IPD_STATS_EN
        stat_clr      = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
        chk("rst_s_tready", DW'(s_axis_tready), DW'(0));
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        axi_reset     = 1'b0;
        @(posedge clk); #1;

        // First packet after reset is never held, even with a large gap.
        send_pkt(2, 1000, 0, -1, 0);
        // Back-to-back 4-beat packets, second with gap 10.
        send_pkt(4, 0, 0, -1, 0);
        send_pkt(4, 10, 0, -1, 0);
        // Gap 0 single-beat packets stream one per cycle.
        c0 = cyc;
        for (int i = 0; i < 6; i++) send_pkt(1, 0, 0, -1, 0);
        chk("b2b_cycles", DW'(cyc - c0), DW'(6));

        // Register-forced gap overrides tuser.
        ipd_use_reg   = 1'b1;
        ipd_reg_value = 32'd5;
        send_pkt(3, 100, 0, -1, 0);
        // Register change during HOLD is ignored.
        ipd_reg_value = 32'd8;
        send_pkt(2, 100, 0, 2, 1);
        // Dropping ipd_en during HOLD releases the packet.
        ipd_reg_value = 32'd50;
        send_pkt(2, 100, 0, 4, 2);
        ipd_en        = 1'b1;
        ipd_use_reg   = 1'b0;

        // Toggling backpressure on an 8-beat packet, then gap from its final handshake.
        send_pkt(8, 3, 1, -1, 0);
        send_pkt(2, 6, 0, -1, 0);
        // Bypass.
        ipd_en = 1'b0;
        send_pkt(2, 40, 0, -1, 0);
        ipd_en = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            int idle;
            idle          = $urandom_range(0, 6);
            ipd_en        = ($urandom_range(0, 9) != 0);
            ipd_use_reg   = 1'($urandom_range(0, 1));
            ipd_reg_value = 32'($urandom_range(0, 12));
            repeat (idle) begin @(posedge clk); #1; end
            send_pkt($urandom_range(1, 5), $urandom_range(0, 15), $urandom_range(0, 2), -1, 0);
        end
        ipd_en      = 1'b1;
        ipd_use_reg = 1'b0;

        // Reset while holding.
        send_pkt(1, 0, 0, -1, 0);
        armed = 1'b0;
        s_axis_tuser  = {64'd0, 32'd1000, 32'd0};
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_busy", DW'(busy), DW'(1));
        chk("hold_m_tvalid", DW'(m_axis_tvalid), DW'(0));
        chk("hold_s_tready", DW'(s_axis_tready), DW'(0));
        do_reset_check("rst_in_hold");

`ifdef PCAP_IPD_STATS_EN
        for (int i = 0; i < 3; i++) send_pkt(2, 0, 0, -1, 0);
        @(negedge clk);
        chk("stat_pkt_cnt_3", DW'(stat_pkt_cnt), DW'(3));
        @(posedge clk); #1;
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        @(negedge clk);
        chk("stat_pkt_cnt_clr", DW'(stat_pkt_cnt), DW'(0));
        @(posedge clk); #1;
        send_pkt(1, 0, 0, -1, 0);
        send_pkt(1, 4, 0, -1, 0);
        @(negedge clk);
        chk("stat_pkt_cnt_2", DW'(stat_pkt_cnt), DW'(2));
        chk("stat_hold_cycles_4", DW'(stat_hold_cycles), DW'(4));
        @(posedge clk); #1;
`endif

        // Reset in the middle of a packet.
        armed = 1'b0;
        m_axis_tready = 1'b0;
        s_axis_tuser  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("send_busy", DW'(busy), DW'(1));
        chk("send_m_tvalid", DW'(m_axis_tvalid), DW'(1));
        do_reset_check("rst_in_send");
`ifdef PCAP_IPD_STATS_EN
        chk("stat_pkt_cnt_rst", DW'(stat_pkt_cnt), DW'(0));
`endif

        // Recovery: first packet after reset passes without hold.
        @(posedge clk); #1;
        send_pkt(3, 1000, 0, -1, 0);
        repeat (3) @(posedge clk);
        chk("sb_drained", DW'(sb.size()), DW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
